// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared datapath word type
package cpu_types_pkg;
  localparam int WORD_W = 32;
  typedef logic [WORD_W-1:0] word_t;
endpackage

// File: rtl/mux_types_pkg.sv
// mux_types_pkg: select encodings for pipeline muxes and the memory-stage FSM
package mux_types_pkg;
  typedef enum logic [1:0] {RF_ALU, RF_MEM, RF_PC4, RF_LUI} rfInMux;
  typedef enum logic {IDLE, HELD} memst_t;
endpackage

// File: rtl/mem_link_reg.sv
// mem_link_reg: LL/SC link register with set, store-clear and snoop-clear priority
// Ports: CLK/nRST; set_i + addr_i (LL hit), st_i (own store hit), sc_ok_i (successful SC hit),
// ccinv_i/ccsnoopaddr_i (snoop invalidate); link_valid_o/link_addr_o current link.
module mem_link_reg
  import cpu_types_pkg::*;
(
  input  logic  CLK,
  input  logic  nRST,
  input  logic  set_i,
  input  logic  st_i,
  input  logic  sc_ok_i,
  input  word_t addr_i,
  input  logic  ccinv_i,
  input  word_t ccsnoopaddr_i,
  output logic  link_valid_o,
  output word_t link_addr_o
);
  logic  r_valid;
  word_t r_addr;
  logic  w_snoop;
  logic  w_clr;
  // a snoop matching either the held link or the link being set this cycle kills it
  assign w_snoop = ccinv_i & ((ccsnoopaddr_i == r_addr) | (set_i & (ccsnoopaddr_i == addr_i)));
  assign w_clr   = sc_ok_i | (st_i & (addr_i == r_addr));
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_valid <= 1'b0;
      r_addr  <= '0;
    end else begin
      if (set_i) r_addr <= addr_i;
      r_valid <= w_snoop ? 1'b0 : set_i ? 1'b1 : w_clr ? 1'b0 : r_valid;
    end
  end
  assign link_valid_o = r_valid;
  assign link_addr_o  = r_addr;
endmodule

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: MEM-stage dcache access control with stall, result hold and LL/SC
// Ports: CLK/nRST; EX/MEM request (dREN_i, dWEN_i, ll_i, sc_i, addr_i, store_i);
// pipe control (pipe_adv_i, flush_i); cache response (dhit_i, dload_i); snoop (ccinv_i,
// ccsnoopaddr_i); cache request (dmemREN_o, dmemWEN_o, dmemaddr_o, dmemstore_o);
// dmemload_o to MEM/WB; mem_stall_o freezes the pipe.
module mem_access_ctrl
  import cpu_types_pkg::*;
  import mux_types_pkg::*;
(
  input  logic  CLK,
  input  logic  nRST,
  input  logic  dREN_i,
  input  logic  dWEN_i,
  input  logic  ll_i,
  input  logic  sc_i,
  input  word_t addr_i,
  input  word_t store_i,
  input  logic  pipe_adv_i,
  input  logic  flush_i,
  input  logic  dhit_i,
  input  word_t dload_i,
  input  logic  ccinv_i,
  input  word_t ccsnoopaddr_i,
  output logic  dmemREN_o,
  output logic  dmemWEN_o,
  output word_t dmemaddr_o,
  output word_t dmemstore_o,
  output word_t dmemload_o,
  output logic  mem_stall_o
);
  memst_t r_state;
  memst_t w_next;
  word_t  r_data;
  word_t  w_link_addr;
  word_t  w_load;
  logic   w_link_valid;
  logic   w_req;
  logic   w_sc_fail;
  logic   w_ren;
  logic   w_wen;
  assign w_req     = (dREN_i | dWEN_i) & ~flush_i;
  assign w_sc_fail = sc_i & ~(w_link_valid & (w_link_addr == addr_i));
  always_comb begin
    w_ren  = (r_state == IDLE) & w_req & dREN_i;
    w_wen  = (r_state == IDLE) & w_req & dWEN_i & ~w_sc_fail;
    w_load = (r_state == HELD) ? r_data :
             dREN_i ? dload_i :
             (dWEN_i & sc_i & ~w_sc_fail) ? word_t'(1) : '0;
    w_next = flush_i ? IDLE :
             (r_state == HELD) ? (pipe_adv_i ? IDLE : HELD) :
             ((w_ren | w_wen) & dhit_i & ~pipe_adv_i) ? HELD : IDLE;
  end
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state <= IDLE;
      r_data  <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && w_next == HELD) r_data <= sc_i ? word_t'(1) : dload_i;
    end
  end
  mem_link_reg u_link (
    .CLK           (CLK),
    .nRST          (nRST),
    .set_i         (w_ren & ll_i & dhit_i),
    .st_i          (w_wen & dhit_i),
    .sc_ok_i       (w_wen & sc_i & dhit_i),
    .addr_i        (addr_i),
    .ccinv_i       (ccinv_i),
    .ccsnoopaddr_i (ccsnoopaddr_i),
    .link_valid_o  (w_link_valid),
    .link_addr_o   (w_link_addr)
  );
  // reset forces every output low immediately, even while the request inputs are still up
  assign dmemREN_o   = nRST & w_ren;
  assign dmemWEN_o   = nRST & w_wen;
  assign mem_stall_o = nRST & (w_ren | w_wen) & ~dhit_i;
  assign dmemaddr_o  = nRST ? addr_i : '0;
  assign dmemstore_o = nRST ? store_i : '0;
  assign dmemload_o  = nRST ? w_load : '0;
endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: directed plus randomized checks of mem_access_ctrl against a reference model
module tb_mem_access_ctrl;
  import cpu_types_pkg::*;
  logic  CLK = 1'b0;
  logic  nRST;
  logic  dREN_i, dWEN_i, ll_i, sc_i, pipe_adv_i, flush_i, dhit_i, ccinv_i;
  word_t addr_i, store_i, dload_i, ccsnoopaddr_i;
  logic  dmemREN_o, dmemWEN_o, mem_stall_o;
  word_t dmemaddr_o, dmemstore_o, dmemload_o;
  int    n_cmp = 0;
  int    n_bad = 0;
  bit    m_valid, m_held;
  word_t m_addr, m_data;
  logic  e_ren, e_wen, e_stall;
  word_t e_load;

  mem_access_ctrl dut (
    .CLK(CLK), .nRST(nRST), .dREN_i(dREN_i), .dWEN_i(dWEN_i), .ll_i(ll_i), .sc_i(sc_i),
    .addr_i(addr_i), .store_i(store_i), .pipe_adv_i(pipe_adv_i), .flush_i(flush_i),
    .dhit_i(dhit_i), .dload_i(dload_i), .ccinv_i(ccinv_i), .ccsnoopaddr_i(ccsnoopaddr_i),
    .dmemREN_o(dmemREN_o), .dmemWEN_o(dmemWEN_o), .dmemaddr_o(dmemaddr_o),
    .dmemstore_o(dmemstore_o), .dmemload_o(dmemload_o), .mem_stall_o(mem_stall_o)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drv(input bit ren, wen, ll, sc, input word_t a, st, input bit adv, fl, hit,
                     input word_t dl, input bit inv, input word_t sa);
    dREN_i = ren; dWEN_i = wen; ll_i = ll; sc_i = sc; addr_i = a; store_i = st;
    pipe_adv_i = adv; flush_i = fl; dhit_i = hit; dload_i = dl; ccinv_i = inv; ccsnoopaddr_i = sa;
  endtask

  task automatic idle();
    drv(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
  endtask

  task automatic model_reset();
    m_valid = 0; m_held = 0; m_addr = 0; m_data = 0;
  endtask

  task automatic model_outs();
    bit linked, req;
    linked = m_valid && (m_addr == addr_i);
    req = (dREN_i || dWEN_i) && !flush_i;
    e_ren = 0; e_wen = 0; e_stall = 0; e_load = 0;
    if (m_held) e_load = m_data;
    else begin
      e_ren = req && dREN_i;
      e_wen = req && dWEN_i && (!sc_i || linked);
      e_stall = (e_ren || e_wen) && !dhit_i;
      if (dREN_i) e_load = dload_i;
      else if (dWEN_i && sc_i && linked) e_load = 1;
    end
  endtask

  task automatic model_update();
    bit done, set, clr, snoop;
    done = !m_held && (e_ren || e_wen) && dhit_i;
    set = done && e_ren && ll_i;
    clr = done && e_wen && (sc_i || addr_i == m_addr);
    snoop = ccinv_i && (ccsnoopaddr_i == m_addr || (set && ccsnoopaddr_i == addr_i));
    m_valid = snoop ? 1'b0 : set ? 1'b1 : clr ? 1'b0 : m_valid;
    if (set) m_addr = addr_i;
    if (flush_i) m_held = 0;
    else if (m_held) m_held = !pipe_adv_i;
    else if (done && !pipe_adv_i) begin
      m_held = 1;
      m_data = sc_i ? 32'd1 : dload_i;
    end
  endtask

  task automatic sample(input string tag);
    #3;
    model_outs();
    chk({tag, "_ren"},   dmemREN_o,   e_ren);
    chk({tag, "_wen"},   dmemWEN_o,   e_wen);
    chk({tag, "_stall"}, mem_stall_o, e_stall);
    chk({tag, "_load"},  dmemload_o,  e_load);
    chk({tag, "_addr"},  dmemaddr_o,  addr_i);
    chk({tag, "_store"}, dmemstore_o, store_i);
  endtask

  task automatic adv_clk();
    model_update();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    nRST = 0;
    idle();
    model_reset();
    #1;
    chk("rst_ren", dmemREN_o, 0);
    chk("rst_wen", dmemWEN_o, 0);
    chk("rst_stall", mem_stall_o, 0);
    chk("rst_load", dmemload_o, 0);
    repeat (2) @(posedge CLK);
    #1;
    nRST = 1;

    drv(1, 0, 0, 0, 32'h100, 0, 0, 0, 0, 32'hDEADBEEF, 0, 0);
    repeat (3) begin
      sample("lw_miss");
      chk("lw_miss_stall_hi", mem_stall_o, 1);
      adv_clk();
    end
    drv(1, 0, 0, 0, 32'h100, 0, 1, 0, 1, 32'hDEADBEEF, 0, 0);
    sample("lw_hit");
    chk("lw_hit_stall_lo", mem_stall_o, 0);
    chk("lw_hit_data", dmemload_o, 32'hDEADBEEF);
    adv_clk();

    drv(1, 0, 0, 0, 32'h100, 0, 0, 0, 1, 32'hDEADBEEF, 0, 0);
    sample("hold_hit");
    chk("hold_hit_ren", dmemREN_o, 1);
    adv_clk();
    drv(1, 0, 0, 0, 32'h100, 0, 0, 0, 1, 32'h12345678, 0, 0);
    repeat (2) begin
      sample("hold_wait");
      chk("hold_wait_ren", dmemREN_o, 0);
      chk("hold_wait_data", dmemload_o, 32'hDEADBEEF);
      adv_clk();
    end
    drv(1, 0, 0, 0, 32'h100, 0, 1, 0, 1, 32'h12345678, 0, 0);
    sample("hold_adv");
    chk("hold_adv_data", dmemload_o, 32'hDEADBEEF);
    adv_clk();

    drv(1, 0, 1, 0, 32'h200, 0, 1, 0, 1, 32'h7, 0, 0);
    sample("ll1");
    adv_clk();
    drv(0, 1, 0, 1, 32'h200, 32'h55, 1, 0, 1, 0, 0, 0);
    sample("sc_ok");
    chk("sc_ok_wen", dmemWEN_o, 1);
    chk("sc_ok_load", dmemload_o, 1);
    chk("sc_ok_store", dmemstore_o, 32'h55);
    adv_clk();
    sample("sc_again");
    chk("sc_again_wen", dmemWEN_o, 0);
    chk("sc_again_load", dmemload_o, 0);
    adv_clk();

    drv(1, 0, 1, 0, 32'h200, 0, 1, 0, 1, 32'h7, 0, 0);
    sample("ll2");
    adv_clk();
    drv(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 32'h200);
    sample("snoop");
    adv_clk();
    drv(0, 1, 0, 1, 32'h200, 32'h55, 1, 0, 0, 0, 0, 0);
    sample("sc_snooped");
    chk("sc_snooped_wen", dmemWEN_o, 0);
    chk("sc_snooped_load", dmemload_o, 0);
    chk("sc_snooped_stall", mem_stall_o, 0);
    adv_clk();

    drv(1, 0, 1, 0, 32'h200, 0, 1, 0, 1, 32'h7, 1, 32'h200);
    sample("ll_race");
    adv_clk();
    drv(0, 1, 0, 1, 32'h200, 32'h9, 1, 0, 1, 0, 0, 0);
    sample("sc_race");
    chk("sc_race_wen", dmemWEN_o, 0);
    chk("sc_race_load", dmemload_o, 0);
    adv_clk();

    drv(1, 0, 0, 0, 32'h300, 0, 0, 0, 0, 32'hA5A5A5A5, 0, 0);
    sample("rst_miss");
    chk("rst_miss_stall", mem_stall_o, 1);
    #2;
    nRST = 0;
    #1;
    chk("async_rst_ren", dmemREN_o, 0);
    chk("async_rst_stall", mem_stall_o, 0);
    chk("async_rst_load", dmemload_o, 0);
    chk("async_rst_addr", dmemaddr_o, 0);
    model_reset();
    @(posedge CLK);
    #1;
    idle();
    nRST = 1;
    sample("post_rst");
    chk("post_rst_ren", dmemREN_o, 0);
    adv_clk();

    drv(1, 0, 0, 0, 32'h140, 0, 0, 0, 1, 32'hCAFE0001, 0, 0);
    sample("fl_hit");
    adv_clk();
    drv(1, 0, 0, 0, 32'h140, 0, 0, 1, 0, 32'h0, 0, 0);
    sample("fl_held");
    chk("fl_held_data", dmemload_o, 32'hCAFE0001);
    adv_clk();
    drv(1, 0, 0, 0, 32'h140, 0, 0, 0, 0, 32'h0, 0, 0);
    sample("fl_idle");
    chk("fl_idle_ren", dmemREN_o, 1);
    adv_clk();

    for (int i = 0; i < 600; i++) begin
      bit ld, st;
      word_t a;
      ld = ($urandom_range(0, 2) == 0);
      st = !ld && ($urandom_range(0, 1) == 0);
      a = 32'h100 * $urandom_range(1, 3);
      drv(ld, st, ld && ($urandom_range(0, 1) == 0), st && ($urandom_range(0, 1) == 0), a,
          $urandom, $urandom_range(0, 2) != 0, $urandom_range(0, 9) == 0,
          $urandom_range(0, 1) == 0, $urandom, $urandom_range(0, 5) == 0,
          32'h100 * $urandom_range(1, 3));
      sample("rand");
      adv_clk();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Memory-stage access controller sitting between the EX/MEM pipe register and the MEM/WB pipe register. It issues data-cache read/write requests, stalls the pipeline until the cache hits, and presents load data to MEM/WB on the edge the pipe advances. It holds a completed access's data when the pipe is frozen by another stall source, so the access is never re-issued. It also implements LL/SC with a link register that snoop invalidations clear.

## Interface
Parameters:
- none (`word_t` is 32 bits, from `cpu_types_pkg`)

Ports:
- `CLK` in 1: clock, rising edge.
- `nRST` in 1: asynchronous, active-low reset.
- `dREN_i` in 1: EX/MEM instruction is a load (LW/LL).
- `dWEN_i` in 1: EX/MEM instruction is a store (SW/SC).
- `ll_i` in 1: instruction is LL (qualifies `dREN_i`).
- `sc_i` in 1: instruction is SC (qualifies `dWEN_i`).
- `addr_i` in 32: effective address (ALU out).
- `store_i` in 32: store data.
- `pipe_adv_i` in 1: global EN for EX/MEM→MEM/WB this cycle.
- `flush_i` in 1: MEM stage squash.
- `dhit_i` in 1: cache hit/done.
- `dload_i` in 32: cache read data.
- `ccinv_i` in 1: snoop invalidate valid.
- `ccsnoopaddr_i` in 32: snooped address.
- `dmemREN_o` out 1: cache read request.
- `dmemWEN_o` out 1: cache write request.
- `dmemaddr_o` out 32: cache address (`addr_i`).
- `dmemstore_o` out 32: cache write data (`store_i`).
- `dmemload_o` out 32: data to MEM/WB `dmemload_i`.
- `mem_stall_o` out 1: deasserts every pipe EN.

## Operation
- Request = `(dREN_i | dWEN_i) & ~flush_i`. An SC with `link_valid=0` or `link_addr≠addr_i` is a failed SC: no cache request.
- States (`memst_t`):
  - `IDLE`: no outstanding completed access.
  - `HELD`: access completed, waiting for the pipe to advance.
- In `IDLE`:
  - `dmemREN_o` = request & load. `dmemWEN_o` = request & store & not failed-SC.
  - `mem_stall_o` = (`dmemREN_o` | `dmemWEN_o`) & `~dhit_i`.
  - On `dhit_i` with `pipe_adv_i=0`: capture `dload_i` (SC: 1) into `data_r` and go to `HELD`.
- In `HELD`:
  - `dmemREN_o` = `dmemWEN_o` = 0; `mem_stall_o` = 0.
  - `dmemload_o` = `data_r`.
  - On `pipe_adv_i` or `flush_i`, return to `IDLE`.
- `dmemload_o` in `IDLE`:
  - load: `dload_i`
  - successful SC: 32'd1
  - failed SC: 32'd0
  - otherwise: 32'd0
- Link register (`link_valid`, `link_addr`):
  - LL hit in `IDLE`: set `link_valid=1`, `link_addr=addr_i`.
  - Cleared by a successful SC, by own SW/SC hit to `link_addr`, or by `ccinv_i & ccsnoopaddr_i==link_addr`.
  - Simultaneous LL set and snoop clear in the same cycle: the snoop wins (`link_valid=0`).
- Address compare is full 32-bit; word alignment is the issuer's responsibility.

## Timing
- Reset values:
  - all outputs 0
  - state `IDLE`, `data_r=0`, `link_valid=0`, `link_addr=0`
- Hit latency is combinational: `dhit_i` in cycle N releases `mem_stall_o` in cycle N, and MEM/WB latches `dmemload_o` at the end of cycle N.
- Miss: `mem_stall_o` stays high each cycle until `dhit_i`. Request outputs remain stable and level-held.
- `flush_i` takes priority over every transition and forces `IDLE`. The link register is not affected by a flush.
- `nRST` asserted mid-access: immediate return to reset values, and the access is dropped.

## Structure
- Add `memst_t` (`IDLE`, `HELD`) to `mux_types_pkg` alongside `rfInMux`. `word_t` comes from `cpu_types_pkg`.
- One sub-module, `mem_link_reg`, holds the link valid/address register with set/clear/snoop priority logic.
- The top level holds the FSM, the `data_r` holding register and the output muxing.

## Test plan
- LW to 0x100 with `dhit_i` after 3 cycles, memory holds 0xDEADBEEF: `mem_stall_o` high for 3 cycles, then `dmemload_o`=0xDEADBEEF at the hit cycle with stall low.
- LW hit while `pipe_adv_i=0` for 2 more cycles: one `dmemREN_o` pulse only, `HELD` entered, `dmemload_o` stays 0xDEADBEEF until the advance.
- LL 0x200 then SC 0x200 with `store_i`=0x55: write issued, `dmemload_o`=1, `link_valid`=0 afterward.
- LL 0x200, then `ccinv_i` with snoop address 0x200, then SC 0x200: `dmemWEN_o` never asserts, `dmemload_o`=0, no stall.
- LL with snoop to the same address in the same cycle: `link_valid`=0. A following SC fails.
- `nRST` pulsed low during a miss: all outputs 0 asynchronously and no request after reset releases. `flush_i` in `HELD` returns to `IDLE` next edge.
